div_ctrl: RTL and testbench

Sequencing controller between the EX stage and the iterative 32-bit divider. Accepts DIV/DIVU requests from EX and latches the operands. Drives and holds the divider's start/operand handshake, stalls the pipeline until the result is ready, then issues a single HI/LO write. Handles pipeline flush (exception) by aborting or draining the divider, so that a following request never sees a divider in a non-free state.

---
 rtl/div_ctrl.sv | 130 +++++++++++++
 tb/tb_div_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and the iterative 32-bit divider.
// Latches a DIV/DIVU request, holds the divider handshake, stalls until ready and issues one HI/LO write.
module div_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        div_valid_i,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        dv_start_o,
    output logic        dv_signed_o,
    output logic [31:0] dv_op1_o,
    output logic [31:0] dv_op2_o,
    output logic        dv_flush_o,
    input  logic [63:0] dv_result_i,
    input  logic        dv_ready_i
);

    localparam int CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic          signed_q, signed_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign dv_start_o  = start_q;
    assign dv_signed_o = signed_q;
    assign dv_op1_o    = op1_q;
    assign dv_op2_o    = op2_q;
    assign dv_flush_o  = flush_i;
    assign hi_o        = dv_result_i[63:32];
    assign lo_o        = dv_result_i[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            cnt_q    <= cnt_d;
        end
    end

    // Operands stay put outside an accepted request: the divider re-reads them during sign fixup.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                start_d = 1'b0;
                if (div_valid_i && !flush_i) begin
                    op1_d    = op1_i;
                    op2_d    = op2_i;
                    signed_d = div_signed_i;
                    start_d  = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    start_d = 1'b0;
                    cnt_d   = CW'(DRAIN_CYCLES);
                    state_d = DRAIN;
                end else if (dv_ready_i) begin
                    start_d = 1'b0;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                start_d = 1'b0;
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Flush outranks a same-cycle ready, so an aborted divide can never write HI/LO.
    always_comb begin
        stall_o   = 1'b0;
        hilo_we_o = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:  stall_o = div_valid_i && !flush_i;
                BUSY: begin
                    if (flush_i) begin
                        stall_o = 1'b0;
                    end else if (dv_ready_i) begin
                        hilo_we_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                DRAIN: stall_o = div_valid_i && !flush_i;
                default: stall_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a behavioural iterative divider stub plus a HI/LO scoreboard.
// Vectors run from a table; flush, back-to-back and reset cases are hand-written sequences.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flushIn;
    logic        divValid;
    logic        divSigned;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        dv_start_o;
    logic        dv_signed_o;
    logic [31:0] dv_op1_o;
    logic [31:0] dv_op2_o;
    logic        dv_flush_o;
    logic [63:0] dvResult;
    logic        dvReady;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [63:0] expQ[$];

    typedef struct {
        logic        sgn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vec_t;

    vec_t vecs[8];

    div_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .flush_i(flushIn),
        .div_valid_i(divValid), .div_signed_i(divSigned),
        .op1_i(op1), .op2_i(op2),
        .stall_o(stall_o), .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o),
        .dv_start_o(dv_start_o), .dv_signed_o(dv_signed_o),
        .dv_op1_o(dv_op1_o), .dv_op2_o(dv_op2_o), .dv_flush_o(dv_flush_o),
        .dv_result_i(dvResult), .dv_ready_i(dvReady)
    );

    always #5 clk = ~clk;

    // Divider stub with nominal timing: 33 iteration cycles, or a two-cycle path for a zero divisor.
    typedef enum {D_FREE, D_ZERO, D_ON, D_END} dstate_t;
    dstate_t dState;
    int      dCnt;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    always @(posedge clk) begin
        if (rst) begin
            dState <= D_FREE;
            dCnt   <= 0;
        end else begin
            case (dState)
                D_FREE: if (dv_start_o && !dv_flush_o) begin
                    dState <= (dv_op2_o == 32'd0) ? D_ZERO : D_ON;
                    dCnt   <= 0;
                end
                D_ZERO: dState <= D_END;
                D_ON: begin
                    if (dv_flush_o) dState <= D_FREE;
                    else if (dCnt == 32) dState <= D_END;
                    else dCnt <= dCnt + 1;
                end
                D_END: if (!dv_start_o) dState <= D_FREE;
                default: dState <= D_FREE;
            endcase
        end
    end

    always_comb begin
        sq       = '0;
        sr       = '0;
        dvReady  = (dState == D_END);
        dvResult = '0;
        if (dState == D_END && dv_op2_o != 32'd0) begin
            if (dv_signed_o) begin
                sq       = $signed(dv_op1_o) / $signed(dv_op2_o);
                sr       = $signed(dv_op1_o) % $signed(dv_op2_o);
                dvResult = {sr, sq};
            end else begin
                dvResult = {dv_op1_o % dv_op2_o, dv_op1_o / dv_op2_o};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        divValid  = 1'b1;
        divSigned = sgn;
        op1       = a;
        op2       = b;
    endtask

    // Every HI/LO write must match the oldest expected result; a write with nothing pending is an error.
    always @(negedge clk) begin
        #1;
        if (hilo_we_o) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected write: got hi=%h lo=%h, expected no write", hi_o, lo_o);
            end else begin
                checkOutput("hi/lo write", {hi_o, lo_o}, expQ.pop_front());
            end
        end
    end

    // Presents a request at the current negedge and follows it until the write; returns at the next negedge.
    task automatic runDiv(input vec_t v, input int lat);
        int cyc;
        int stallCnt;
        int weCyc;
        bit stable;
        bit startHeld;
        applyStimulus(v.sgn, v.op1, v.op2);
        expQ.push_back({v.expHi, v.expLo});
        cyc       = 0;
        stallCnt  = 0;
        weCyc     = -1;
        stable    = 1'b1;
        startHeld = 1'b0;
        while (weCyc < 0 && cyc < 200) begin
            #1;
            if (hilo_we_o) begin
                weCyc     = cyc;
                startHeld = dv_start_o;
                checkOutput("stall released on write", 64'(stall_o), 64'd0);
            end else if (stall_o) begin
                stallCnt++;
            end
            if (dv_start_o && {dv_signed_o, dv_op1_o, dv_op2_o} != {v.sgn, v.op1, v.op2})
                stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        divValid = 1'b0;
        checkOutput("write latency", 64'(weCyc), 64'(lat));
        checkOutput("stall cycles", 64'(stallCnt), 64'(lat));
        checkOutput("operands held", 64'(stable), 64'd1);
        checkOutput("start held to write", 64'(startHeld), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         35};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   35};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   35};
        vecs[3] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          3};
        vecs[4] = '{1'b1, 32'h80000000,   32'd0,          32'd0,          32'd0,          3};
        vecs[5] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'd1,          32'h7FFFFFFC,   35};
        vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14,         35};
        vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'h00000010,   32'h0000000F,   32'h0FFFFFFF,   35};

        rst = 1'b1; flushIn = 1'b0; divValid = 1'b0; divSigned = 1'b0; op1 = '0; op2 = '0;
        @(negedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 32'd9, 32'd3);
        #1;
        checkOutput("reset stall", 64'(stall_o), 64'd0);
        checkOutput("reset hilo_we", 64'(hilo_we_o), 64'd0);
        checkOutput("reset divider drive", {31'd0, dv_start_o, dv_signed_o, dv_op1_o}, 64'd0);
        checkOutput("reset op2", 64'(dv_op2_o), 64'd0);
        @(negedge clk);
        divValid = 1'b0;
        rst = 1'b0;

        flushIn = 1'b1;
        #1;
        checkOutput("flush pass-through", 64'(dv_flush_o), 64'd1);
        @(negedge clk);
        flushIn = 1'b0;
        #1;
        checkOutput("flush pass-through low", 64'(dv_flush_o), 64'd0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            runDiv(vecs[i], vecs[i].expLat);
            @(negedge clk);
        end

        v = '{1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 35};
        runDiv(v, 35);
        v = '{1'b0, 32'd7, 32'd3, 32'd1, 32'd2, 35};
        runDiv(v, 35);
        @(negedge clk);

        applyStimulus(1'b0, 32'd1000, 32'd3);
        for (int c = 0; c < 10; c++) @(negedge clk);
        flushIn = 1'b1;
        #1;
        checkOutput("stall on flush", 64'(stall_o), 64'd0);
        checkOutput("no write on flush", 64'(hilo_we_o), 64'd0);
        @(negedge clk);
        flushIn = 1'b0;
        #1;
        checkOutput("start low after flush", 64'(dv_start_o), 64'd0);
        v = '{1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 38};
        runDiv(v, 38);
        @(negedge clk);

        applyStimulus(1'b0, 32'd5, 32'd0);
        for (int c = 0; c < 3; c++) @(negedge clk);
        flushIn = 1'b1;
        #1;
        checkOutput("no write on flush+ready", 64'(hilo_we_o), 64'd0);
        checkOutput("stall on flush+ready", 64'(stall_o), 64'd0);
        @(negedge clk);
        flushIn = 1'b0;
        v = '{1'b0, 32'd10, 32'd4, 32'd2, 32'd2, 38};
        runDiv(v, 38);
        @(negedge clk);

        applyStimulus(1'b1, 32'd100, 32'd7);
        for (int c = 0; c < 10; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("stall under reset", 64'(stall_o), 64'd0);
        checkOutput("no write under reset", 64'(hilo_we_o), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("reset mid-divide drive", {31'd0, dv_start_o, dv_signed_o, dv_op1_o}, 64'd0);
        checkOutput("reset mid-divide op2", 64'(dv_op2_o), 64'd0);
        divValid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        v = '{1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 35};
        runDiv(v, 35);
        @(negedge clk);
        @(negedge clk);

        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
